// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the gated CPU bus hub.
package cpu_bus_pkg;

  // Bus occupancy, also used as the registered bus state encoding.
  typedef enum logic [1:0] {
    BUS_IDLE     = 2'd0,
    BUS_DRIVEN   = 2'd1,
    BUS_CONFLICT = 2'd2
  } bus_state_e;

  localparam int DEFAULT_DATA_W = 16;
  localparam logic [DEFAULT_DATA_W-1:0] BUS_IDLE_VAL = '1;

endpackage

// File: rtl/bus_prio_mux.sv
// Lowest-index-wins source select plus none/one/many gate classification.
module bus_prio_mux
  import cpu_bus_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int N_SRC  = 4
) (
  input  logic [N_SRC*DATA_W-1:0] src_data_i,
  input  logic [N_SRC-1:0]        gate_i,
  output logic [DATA_W-1:0]       sel_data_o,
  output bus_state_e              gate_cls_o
);

  always_comb begin
    sel_data_o = '0;
    gate_cls_o = BUS_IDLE;
    // Walk downwards so the lowest set index is the last writer.
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (gate_i[k]) sel_data_o = src_data_i[k*DATA_W +: DATA_W];
    end
    for (int k = 0; k < N_SRC; k++) begin
      if (gate_i[k]) gate_cls_o = (gate_cls_o == BUS_IDLE) ? BUS_DRIVEN : BUS_CONFLICT;
    end
  end

endmodule

// File: rtl/cpu_bus_hub.sv
// Gated bus hub: priority-resolved bus, load registers, contention and idle monitors.
// Optional keeper register enabled by defining CPU_BUS_HUB_KEEPER_EN.
module cpu_bus_hub
  import cpu_bus_pkg::*;
#(
  parameter int                DATA_W       = DEFAULT_DATA_W,
  parameter int                N_SRC        = 4,
  parameter int                N_DST        = 2,
  parameter logic [DATA_W-1:0] IDLE_VAL     = '1,
  parameter int                IDLE_TIMEOUT = 15
) (
  input  logic                    i_CLK,
  input  logic                    i_Reset,
  input  logic [N_SRC*DATA_W-1:0] i_Src_Data,
  input  logic [N_SRC-1:0]        i_Gate,
  input  logic [N_DST-1:0]        i_LD,
  input  logic                    i_Clear_Err,
  output logic [DATA_W-1:0]       o_Bus,
  output logic [N_DST*DATA_W-1:0] o_Dst,
  output logic [1:0]              o_Bus_State,
  output logic                    o_Contention,
  output logic [7:0]              o_Contention_Cnt,
  output logic                    o_Idle_Timeout
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);

  logic [DATA_W-1:0]       sel_data;
  logic [DATA_W-1:0]       undriven;
  bus_state_e              gate_cls;
  bus_state_e              state_q, state_d;
  logic [N_DST*DATA_W-1:0] dst_q;
  logic                    cont_q, cont_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [IW-1:0]           idle_q, idle_d;
  logic                    idle_to_q;

  bus_prio_mux #(.DATA_W(DATA_W), .N_SRC(N_SRC)) u_mux (
    .src_data_i (i_Src_Data),
    .gate_i     (i_Gate),
    .sel_data_o (sel_data),
    .gate_cls_o (gate_cls)
  );

`ifdef CPU_BUS_HUB_KEEPER_EN
  logic [DATA_W-1:0] keeper_q;
  always_ff @(posedge i_CLK) begin
    if (i_Reset)                    keeper_q <= IDLE_VAL;
    else if (gate_cls != BUS_IDLE)  keeper_q <= o_Bus;
  end
  assign undriven = keeper_q;
`else
  assign undriven = IDLE_VAL;
`endif

  assign o_Bus = (gate_cls == BUS_IDLE) ? undriven : sel_data;

  // State follows the gate classification of the cycle just ended.
  always_comb begin
    state_d = state_q;
    state_d = gate_cls;
  end

  // Contention beats a simultaneous clear so the event is never lost.
  always_comb begin
    cont_d = cont_q;
    cnt_d  = cnt_q;
    idle_d = '0;
    if (gate_cls == BUS_CONFLICT) begin
      cont_d = 1'b1;
      if (i_Clear_Err)          cnt_d = 8'd1;
      else if (cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
    end else if (i_Clear_Err) begin
      cont_d = 1'b0;
      cnt_d  = 8'd0;
    end
    if (gate_cls == BUS_IDLE) idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1);
  end

  always_ff @(posedge i_CLK) begin
    if (i_Reset) begin
      state_q   <= BUS_IDLE;
      dst_q     <= '0;
      cont_q    <= 1'b0;
      cnt_q     <= 8'd0;
      idle_q    <= '0;
      idle_to_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cont_q    <= cont_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      idle_to_q <= (idle_d == IDLE_MAX);
      for (int j = 0; j < N_DST; j++) begin
        if (i_LD[j]) dst_q[j*DATA_W +: DATA_W] <= o_Bus;
      end
    end
  end

  assign o_Dst            = dst_q;
  assign o_Bus_State      = state_q;
  assign o_Contention     = cont_q;
  assign o_Contention_Cnt = cnt_q;
  assign o_Idle_Timeout   = idle_to_q;

endmodule

// File: tb/tb_cpu_bus_hub.sv
// Self-checking bench for cpu_bus_hub: cycle model plus directed literal checks.
module tb_cpu_bus_hub;

  logic        clk;
  logic        rst;
  logic [63:0] src;
  logic [3:0]  gate;
  logic [1:0]  ld;
  logic        clr;
  logic [15:0] bus;
  logic [31:0] dst;
  logic [1:0]  bst;
  logic        cont;
  logic [7:0]  cnt;
  logic        ito;

  logic [191:0] p_src;
  logic [5:0]   p_gate;
  logic [2:0]   p_ld;
  logic         p_clr;
  logic [31:0]  p_bus;
  logic [95:0]  p_dst;
  logic [1:0]   p_bst;
  logic         p_cont;
  logic [7:0]   p_cnt;
  logic         p_ito;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  cpu_bus_hub dut (
    .i_CLK(clk), .i_Reset(rst), .i_Src_Data(src), .i_Gate(gate), .i_LD(ld),
    .i_Clear_Err(clr), .o_Bus(bus), .o_Dst(dst), .o_Bus_State(bst),
    .o_Contention(cont), .o_Contention_Cnt(cnt), .o_Idle_Timeout(ito)
  );

  cpu_bus_hub #(.DATA_W(32), .N_SRC(6), .N_DST(3)) dut_p (
    .i_CLK(clk), .i_Reset(rst), .i_Src_Data(p_src), .i_Gate(p_gate), .i_LD(p_ld),
    .i_Clear_Err(p_clr), .o_Bus(p_bus), .o_Dst(p_dst), .o_Bus_State(p_bst),
    .o_Contention(p_cont), .o_Contention_Cnt(p_cnt), .o_Idle_Timeout(p_ito)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // behavioural model
  logic [15:0] m_dst [2];
  int          m_state, m_cnt, m_idle;
  logic        m_cont, m_to;
  logic [15:0] m_keep;

  function automatic logic [15:0] model_bus();
    logic [15:0] r;
    logic        found;
    found = 1'b0;
`ifdef CPU_BUS_HUB_KEEPER_EN
    r = m_keep;
`else
    r = 16'hFFFF;
`endif
    for (int k = 0; k < 4; k++) begin
      if (gate[k] && !found) begin
        r = src[k*16 +: 16];
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_dst[0] <= 16'h0;
      m_dst[1] <= 16'h0;
      m_state  <= 0;
      m_cont   <= 1'b0;
      m_cnt    <= 0;
      m_idle   <= 0;
      m_to     <= 1'b0;
      m_keep   <= 16'hFFFF;
    end else begin
      if (ld[0]) m_dst[0] <= model_bus();
      if (ld[1]) m_dst[1] <= model_bus();
      m_state <= ($countones(gate) >= 2) ? 2 : $countones(gate);
      if ($countones(gate) >= 2) begin
        m_cont <= 1'b1;
        m_cnt  <= clr ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
      end else if (clr) begin
        m_cont <= 1'b0;
        m_cnt  <= 0;
      end
      if (gate == 4'b0) begin
        m_idle <= (m_idle + 1 > 15) ? 15 : m_idle + 1;
        m_to   <= (m_idle + 1 >= 15);
      end else begin
        m_idle <= 0;
        m_to   <= 1'b0;
      end
      if (gate != 4'b0) m_keep <= model_bus();
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("bus",     64'(bus),   64'(model_bus()));
      check("dst0",    64'(dst[15:0]),  64'(m_dst[0]));
      check("dst1",    64'(dst[31:16]), 64'(m_dst[1]));
      check("state",   64'(bst),   64'(m_state));
      check("cont",    64'(cont),  64'(m_cont));
      check("cnt",     64'(cnt),   64'(m_cnt));
      check("timeout", 64'(ito),   64'(m_to));
    end
  end

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] l;
    logic       c;
  } vec_t;

  vec_t vecs [8];

  initial begin
    rst = 1'b1; src = '0; gate = '0; ld = '0; clr = 1'b0;
    p_src = '0; p_gate = '0; p_ld = '0; p_clr = 1'b0;
    cycle();
    cmp_en = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_dst",   64'(dst), 64'h0);
    check("rst_state", 64'(bst), 64'h0);
    check("rst_cont",  64'(cont), 64'h0);
    check("rst_cnt",   64'(cnt), 64'h0);
    check("rst_to",    64'(ito), 64'h0);
    check("rst_p_dst", 64'(p_dst[63:0]), 64'h0);

    // idle run and timeout
    for (int i = 1; i <= 16; i++) begin
      #1;
      check("idle_bus", 64'(bus), 64'hFFFF);
      cycle();
      if (i == 14) check("to_before", 64'(ito), 64'h0);
      if (i == 15) check("to_rise",   64'(ito), 64'h1);
    end
    src[15:0] = 16'h5555;
    gate = 4'b0001;
    #1;
    check("gate0_bus", 64'(bus), 64'h5555);
    cycle();
    check("to_drop", 64'(ito), 64'h0);

    // two-source contention with load
    src[31:16] = 16'h1234;
    src[47:32] = 16'hABCD;
    gate = 4'b0110;
    ld   = 2'b01;
    #1;
    check("conf_bus", 64'(bus), 64'h1234);
    cycle();
    check("conf_dst0",  64'(dst[15:0]), 64'h1234);
    check("conf_state", 64'(bst), 64'h2);
    check("conf_flag",  64'(cont), 64'h1);
    check("conf_cnt",   64'(cnt), 64'h1);

    // saturation, then clear racing contention
    ld = 2'b00;
    repeat (299) cycle();
    check("sat_cnt", 64'(cnt), 64'd255);
    clr = 1'b1;
    cycle();
    check("clr_race_flag", 64'(cont), 64'h1);
    check("clr_race_cnt",  64'(cnt), 64'h1);
    gate = 4'b0000;
    cycle();
    check("clr_flag", 64'(cont), 64'h0);
    check("clr_cnt",  64'(cnt), 64'h0);
    clr = 1'b0;

    // keeper behaviour
    src[63:48] = 16'h00C3;
    gate = 4'b1000;
    cycle();
    gate = 4'b0000;
    ld   = 2'b10;
    #1;
`ifdef CPU_BUS_HUB_KEEPER_EN
    check("keep_bus", 64'(bus), 64'h00C3);
    cycle();
    check("keep_dst1", 64'(dst[31:16]), 64'h00C3);
`else
    check("keep_bus", 64'(bus), 64'hFFFF);
    cycle();
    check("keep_dst1", 64'(dst[31:16]), 64'hFFFF);
`endif

    // reset overrides loads and contention
    src[15:0]  = 16'h1111;
    src[31:16] = 16'h2222;
    gate = 4'b0011;
    ld   = 2'b11;
    cycle();
    cycle();
    check("pre_rst_cnt", 64'(cnt), 64'h2);
    rst = 1'b1;
    cycle();
    check("ovr_dst",   64'(dst), 64'h0);
    check("ovr_state", 64'(bst), 64'h0);
    check("ovr_cnt",   64'(cnt), 64'h0);
    check("ovr_flag",  64'(cont), 64'h0);
    rst = 1'b0;
    cycle();
    check("restart_cnt", 64'(cnt), 64'h1);
    check("restart_dst", 64'(dst), 64'h1111_1111);

    // directed mix, checked by the model each cycle
    vecs[0] = '{g: 4'b0000, l: 2'b11, c: 1'b0};
    vecs[1] = '{g: 4'b0100, l: 2'b01, c: 1'b0};
    vecs[2] = '{g: 4'b1010, l: 2'b10, c: 1'b0};
    vecs[3] = '{g: 4'b1111, l: 2'b11, c: 1'b1};
    vecs[4] = '{g: 4'b0000, l: 2'b00, c: 1'b1};
    vecs[5] = '{g: 4'b1000, l: 2'b01, c: 1'b0};
    vecs[6] = '{g: 4'b1100, l: 2'b00, c: 1'b0};
    vecs[7] = '{g: 4'b0010, l: 2'b10, c: 1'b0};
    src = 64'h4444_3333_2222_1111;
    for (int v = 0; v < 8; v++) begin
      gate = vecs[v].g;
      ld   = vecs[v].l;
      clr  = vecs[v].c;
      cycle();
    end
    gate = '0; ld = '0; clr = 1'b0;
    cycle();

    // wide configuration sweep
    for (int k = 0; k < 6; k++) p_src[k*32 +: 32] = 32'h1111_1111 * (k + 1);
    for (int k = 0; k < 6; k++) begin
      p_gate = 6'(1 << k);
      #1;
      check("sweep_bus", 64'(p_bus), 64'(32'h1111_1111 * (k + 1)));
      cycle();
    end
    p_gate = 6'b110100;
    #1;
    check("sweep_prio", 64'(p_bus), 64'h3333_3333);
    p_gate = 6'b001000;
    p_ld   = 3'b111;
    cycle();
    check("sweep_dst0", 64'(p_dst[31:0]),  64'h4444_4444);
    check("sweep_dst1", 64'(p_dst[63:32]), 64'h4444_4444);
    check("sweep_dst2", 64'(p_dst[95:64]), 64'h4444_4444);
    p_gate = '0;
    p_ld   = '0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
